peg_l2_rs_rmii_tx: RTL

PEG_L2_RS_RMII_TX -- requirements
Module: peg_l2_rs_rmii_tx

---
 rtl/peg_l2_pkg.sv | 17 +
 rtl/peg_l2_rs_rmii_tick_gen.sv | 29 ++
 rtl/peg_l2_rs_rmii_tx.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/peg_l2_pkg.sv
// Shared layer-2 constants and helpers for the RMII reconciliation sublayer.
package peg_l2_pkg;

    // Seven preamble octets followed by the start-of-frame delimiter, sent LSB first.
    localparam logic [55:0] PREAMBLE_VALUE    = 56'h55_5555_5555_5555;
    localparam logic [7:0]  SFD_VALUE         = 8'hD5;

    // Default minimum inter-frame gap in bytes.
    localparam int          IFG_BYTES_DEFAULT = 12;

    // Index of the last dibit of a word holding nbytes valid bytes (0 means 8).
    // The 5-bit wrap of 0 - 1 gives 31, which is exactly the full-word case.
    function automatic logic [4:0] last_dibit_idx(input logic [2:0] nbytes);
        return {nbytes, 2'b00} - 5'd1;
    endfunction

endpackage

// File: rtl/peg_l2_rs_rmii_tick_gen.sv
// Dibit strobe for RMII: every ref_clk at 100 Mbps, every tenth ref_clk at 10 Mbps.
// Shared by the TX and RX sides of the reconciliation sublayer.
module peg_l2_rs_rmii_tick_gen (
    input  logic clk,
    input  logic rst_n,
    input  logic speed,
    input  logic enable,
    output logic tick
);

    logic [3:0] cnt_r;

    // Divide-by-ten counter, parked at zero while disabled or running at full rate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 4'd0;
        end else if (!enable || speed) begin
            cnt_r <= 4'd0;
        end else if (cnt_r == 4'd9) begin
            cnt_r <= 4'd0;
        end else begin
            cnt_r <= cnt_r + 4'd1;
        end
    end

    // Decoded straight from the counter register, so it is glitch-free
    assign tick = enable & (speed | (cnt_r == 4'd9));

endmodule

// File: rtl/peg_l2_rs_rmii_tx.sv
// RMII transmit reconciliation sublayer: serialises packet words into dibits,
// prefixes preamble/SFD, enforces the inter-frame gap and flags underruns.
module peg_l2_rs_rmii_tx
    import peg_l2_pkg::*;
#(
    parameter int PKT_DATA_W = 64,
    parameter int IFG_BYTES  = IFG_BYTES_DEFAULT
) (
    input  logic                  ref_clk,
    input  logic                  rst_n,
    input  logic                  rs_mii_speed_100_n_10,
    input  logic                  valid,
    input  logic                  sop,
    input  logic                  eop,
    input  logic [2:0]            bytes,
    input  logic [PKT_DATA_W-1:0] data,
    input  logic                  error,
    output logic                  ready,
    output logic [1:0]            txd,
    output logic                  tx_en,
    output logic                  rs_tx_underrun
);

    typedef enum logic [1:0] {
        IDLE_S     = 2'd0,
        PREAMBLE_S = 2'd1,
        DATA_S     = 2'd2,
        IFG_S      = 2'd3
    } state_t;

    localparam logic [63:0] PREAMBLE_WORD = {SFD_VALUE, PREAMBLE_VALUE};
    localparam logic [15:0] IFG_LAST      = 16'(IFG_BYTES * 4 - 1);

    state_t                  state_r, state_nxt_s;
    logic [4:0]              dib_r, dib_nxt_s, dib_inc_s;
    logic [15:0]             ifg_r, ifg_nxt_s;
    logic [PKT_DATA_W-1:0]   hold_data_r, hold_data_nxt_s;
    logic                    hold_eop_r, hold_eop_nxt_s;
    logic [2:0]              hold_bytes_r, hold_bytes_nxt_s;
    logic                    spd_r, spd_nxt_s;
    logic [1:0]              txd_r, txd_nxt_s;
    logic                    tx_en_r, tx_en_nxt_s;
    logic                    idle_rdy_r, idle_rdy_nxt_s;
    logic                    underrun_r, underrun_nxt_s;
    logic                    tick_s, tick_en_s;
    logic [4:0]              word_last_s;
    logic                    last_dibit_s;
    logic                    unused_s;

    // RMII has no TX_ER, so the upstream error flag is deliberately dropped.
    assign unused_s = error;

    // The speed used for the whole frame is the one captured at sop.
    assign tick_en_s = (state_r != IDLE_S);

    peg_l2_rs_rmii_tick_gen u_tick_gen (
        .clk    (ref_clk),
        .rst_n  (rst_n),
        .speed  (spd_r),
        .enable (tick_en_s),
        .tick   (tick_s)
    );

    assign dib_inc_s    = dib_r + 5'd1;
    assign word_last_s  = hold_eop_r ? last_dibit_idx(hold_bytes_r) : 5'd31;
    assign last_dibit_s = (dib_r == word_last_s);

    // Idle readiness is registered; the mid-frame request is a one-cycle decode of
    // registered state so it lines up with the tick of the word's last dibit.
    assign ready = idle_rdy_r | ((state_r == DATA_S) & tick_s & last_dibit_s & ~hold_eop_r);

    assign txd            = txd_r;
    assign tx_en          = tx_en_r;
    assign rs_tx_underrun = underrun_r;

    // State and datapath registers; reset returns straight to idle with the line quiet
    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE_S;
            dib_r        <= 5'd0;
            ifg_r        <= 16'd0;
            hold_data_r  <= '0;
            hold_eop_r   <= 1'b0;
            hold_bytes_r <= 3'd0;
            spd_r        <= 1'b0;
            txd_r        <= 2'b00;
            tx_en_r      <= 1'b0;
            idle_rdy_r   <= 1'b0;
            underrun_r   <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            dib_r        <= dib_nxt_s;
            ifg_r        <= ifg_nxt_s;
            hold_data_r  <= hold_data_nxt_s;
            hold_eop_r   <= hold_eop_nxt_s;
            hold_bytes_r <= hold_bytes_nxt_s;
            spd_r        <= spd_nxt_s;
            txd_r        <= txd_nxt_s;
            tx_en_r      <= tx_en_nxt_s;
            idle_rdy_r   <= idle_rdy_nxt_s;
            underrun_r   <= underrun_nxt_s;
        end
    end

    // Next-state and next-output decode for the transmit sequencer
    always_comb begin
        state_nxt_s      = state_r;
        dib_nxt_s        = dib_r;
        ifg_nxt_s        = ifg_r;
        hold_data_nxt_s  = hold_data_r;
        hold_eop_nxt_s   = hold_eop_r;
        hold_bytes_nxt_s = hold_bytes_r;
        spd_nxt_s        = spd_r;
        txd_nxt_s        = txd_r;
        tx_en_nxt_s      = tx_en_r;
        idle_rdy_nxt_s   = idle_rdy_r;
        underrun_nxt_s   = 1'b0;

        case (state_r)
            IDLE_S: begin
                idle_rdy_nxt_s = 1'b1;
                if (idle_rdy_r && valid && sop) begin
                    hold_data_nxt_s  = data;
                    hold_eop_nxt_s   = eop;
                    hold_bytes_nxt_s = bytes;
                    spd_nxt_s        = rs_mii_speed_100_n_10;
                    dib_nxt_s        = 5'd0;
                    txd_nxt_s        = PREAMBLE_WORD[1:0];
                    tx_en_nxt_s      = 1'b1;
                    idle_rdy_nxt_s   = 1'b0;
                    state_nxt_s      = PREAMBLE_S;
                end else begin
                    // Words without sop are accepted here and simply discarded.
                    txd_nxt_s   = 2'b00;
                    tx_en_nxt_s = 1'b0;
                end
            end

            PREAMBLE_S: begin
                if (tick_s && (dib_r == 5'd31)) begin
                    dib_nxt_s   = 5'd0;
                    txd_nxt_s   = hold_data_r[1:0];
                    state_nxt_s = DATA_S;
                end else if (tick_s) begin
                    dib_nxt_s = dib_inc_s;
                    txd_nxt_s = PREAMBLE_WORD[{dib_inc_s, 1'b0} +: 2];
                end else begin
                    dib_nxt_s = dib_r;
                end
            end

            DATA_S: begin
                if (tick_s && last_dibit_s) begin
                    if (hold_eop_r) begin
                        txd_nxt_s   = 2'b00;
                        tx_en_nxt_s = 1'b0;
                        ifg_nxt_s   = 16'd0;
                        state_nxt_s = IFG_S;
                    end else if (valid && !sop) begin
                        // Next word continues on the very next dibit slot.
                        hold_data_nxt_s  = data;
                        hold_eop_nxt_s   = eop;
                        hold_bytes_nxt_s = bytes;
                        dib_nxt_s        = 5'd0;
                        txd_nxt_s        = data[1:0];
                    end else begin
                        // Missing word, or a stray sop mid-frame: abort the frame.
                        underrun_nxt_s = 1'b1;
                        txd_nxt_s      = 2'b00;
                        tx_en_nxt_s    = 1'b0;
                        ifg_nxt_s      = 16'd0;
                        state_nxt_s    = IFG_S;
                    end
                end else if (tick_s) begin
                    dib_nxt_s = dib_inc_s;
                    txd_nxt_s = hold_data_r[{dib_inc_s, 1'b0} +: 2];
                end else begin
                    dib_nxt_s = dib_r;
                end
            end

            IFG_S: begin
                txd_nxt_s   = 2'b00;
                tx_en_nxt_s = 1'b0;
                if (tick_s && (ifg_r == IFG_LAST)) begin
                    ifg_nxt_s      = 16'd0;
                    idle_rdy_nxt_s = 1'b1;
                    state_nxt_s    = IDLE_S;
                end else if (tick_s) begin
                    ifg_nxt_s = ifg_r + 16'd1;
                end else begin
                    ifg_nxt_s = ifg_r;
                end
            end

            default: begin
                txd_nxt_s      = 2'b00;
                tx_en_nxt_s    = 1'b0;
                idle_rdy_nxt_s = 1'b0;
                state_nxt_s    = IDLE_S;
            end
        endcase
    end

endmodule
